// File: rtl/auto_steer_ctrl_if.sv
// Sample and command bus for auto_steer_ctrl: per-frame error samples in,
// movement commands out.
interface auto_steer_ctrl_if #(
  parameter int ERR_W   = 32,
  parameter int SPEED_W = 4
);
  logic signed [ERR_W-1:0] error;
  logic                    error_valid;
  logic                    line_lost;
  // cmd_valid rises with a command and holds it (stable) until cmd_valid && cmd_ready
  // completes the transfer; only a newer result may replace an unaccepted one.
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [3:0]              move_cmd;
  logic [SPEED_W-1:0]      speed_level;
  logic                    overrun;

  modport master (
    input  error, error_valid, line_lost, cmd_ready,
    output cmd_valid, move_cmd, speed_level, overrun
  );

  modport slave (
    output error, error_valid, line_lost, cmd_ready,
    input  cmd_valid, move_cmd, speed_level, overrun
  );
endinterface

// File: rtl/auto_steer_ctrl.sv
// Line-following steering controller: PD term with deadband/saturation,
// lost-line search FSM, and a latest-wins valid/ready command register.
module auto_steer_ctrl #(
  parameter int                 ERR_W         = 32,
  parameter logic signed [15:0] K_P           = 16'sd71,
  parameter logic signed [15:0] K_D           = 16'sd0,
  parameter int                 SHIFT         = 6,
  parameter int                 DEADBAND      = 0,
  parameter int                 SPEED_W       = 4,
  parameter int                 MAX_LEVEL     = 15,
  parameter int                 BASE_SPEED    = 1,
  parameter int                 SEARCH_SPEED  = 5,
  parameter int                 SEARCH_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 reset_n,
  auto_steer_ctrl_if.master    bus,
  output logic [1:0]           state
);
  localparam int UW = ERR_W + 18;

  localparam logic [3:0] CMD_W    = 4'b0000;
  localparam logic [3:0] CMD_WA   = 4'b0001;
  localparam logic [3:0] CMD_WD   = 4'b0010;
  localparam logic [3:0] CMD_A    = 4'b0100;
  localparam logic [3:0] CMD_D    = 4'b0101;
  localparam logic [3:0] CMD_STOP = 4'b1000;

  localparam logic signed [UW-1:0] DB_S     = UW'(DEADBAND);
  localparam logic signed [UW-1:0] MAX_S    = UW'(MAX_LEVEL);
  localparam logic [SPEED_W-1:0]   MAX_SPD  = SPEED_W'(MAX_LEVEL);
  localparam logic [SPEED_W-1:0]   BASE_SPD = SPEED_W'(BASE_SPEED);
  localparam logic [SPEED_W-1:0]   SRCH_SPD = SPEED_W'(SEARCH_SPEED);
  localparam logic [7:0]           SRCH_FR  = 8'(SEARCH_FRAMES);

  typedef enum logic [1:0] {
    TRACK  = 2'b00,
    SEARCH = 2'b01,
    LOST   = 2'b10
  } state_t;

  state_t                  state_q;
  logic [3:0]              last_dir;
  logic [7:0]              cnt;
  logic signed [ERR_W-1:0] e_prev;
  logic                    d_valid;
  logic                    s1_valid;
  logic [3:0]              s1_cmd;
  logic [SPEED_W-1:0]      s1_spd;

  logic signed [UW-1:0] e_x, ep_x, d_x, kp_x, kd_x, sum, u, mag;
  logic [SPEED_W-1:0]   sat_spd;
  logic [3:0]           trk_cmd;
  logic [SPEED_W-1:0]   trk_spd;
  logic [3:0]           srch_cmd;

  assign state = state_q;

  // The full PD/decode path sits in stage 1 so that a lost sample arriving
  // right after a tracked one already sees that sample's turn direction.
  always_comb begin
    e_x  = {{18{bus.error[ERR_W-1]}}, bus.error};
    ep_x = {{18{e_prev[ERR_W-1]}}, e_prev};
    kp_x = {{(UW-16){K_P[15]}}, K_P};
    kd_x = {{(UW-16){K_D[15]}}, K_D};
    d_x  = '0;
    if (state_q == TRACK && d_valid) d_x = e_x - ep_x;
    sum  = kp_x * e_x + kd_x * d_x;
    u    = sum >>> SHIFT;
    mag  = u[UW-1] ? -u : u;
    sat_spd = (mag > MAX_S) ? MAX_SPD : mag[SPEED_W-1:0];
    trk_cmd = CMD_W;
    trk_spd = BASE_SPD;
    if (u <= DB_S && u >= -DB_S) begin
      trk_cmd = CMD_W;
      trk_spd = BASE_SPD;
    end else if (u[UW-1]) begin
      trk_cmd = CMD_WD;
      trk_spd = sat_spd;
    end else begin
      trk_cmd = CMD_WA;
      trk_spd = sat_spd;
    end
    srch_cmd = (last_dir == CMD_WA) ? CMD_A : CMD_D;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= TRACK;
      last_dir <= CMD_W;
      cnt      <= '0;
      e_prev   <= '0;
      d_valid  <= 1'b0;
      s1_valid <= 1'b0;
      s1_cmd   <= CMD_STOP;
      s1_spd   <= '0;
    end else begin
      s1_valid <= bus.error_valid;
      if (bus.error_valid) begin
        if (!bus.line_lost) begin
          state_q  <= TRACK;
          e_prev   <= bus.error;
          d_valid  <= 1'b1;
          last_dir <= trk_cmd;
          cnt      <= '0;
          s1_cmd   <= trk_cmd;
          s1_spd   <= trk_spd;
        end else begin
          d_valid <= 1'b0;
          case (state_q)
            TRACK: begin
              if (last_dir == CMD_W) begin
                state_q <= LOST;
                s1_cmd  <= CMD_STOP;
                s1_spd  <= '0;
              end else begin
                state_q <= SEARCH;
                cnt     <= 8'd1;
                s1_cmd  <= srch_cmd;
                s1_spd  <= SRCH_SPD;
              end
            end
            SEARCH: begin
              if (cnt < SRCH_FR) begin
                cnt    <= cnt + 8'd1;
                s1_cmd <= srch_cmd;
                s1_spd <= SRCH_SPD;
              end else begin
                state_q <= LOST;
                s1_cmd  <= CMD_STOP;
                s1_spd  <= '0;
              end
            end
            default: begin
              state_q <= LOST;
              s1_cmd  <= CMD_STOP;
              s1_spd  <= '0;
            end
          endcase
        end
      end
    end
  end

  // Latest result always wins; overrun flags a command dropped before acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.cmd_valid   <= 1'b0;
      bus.move_cmd    <= CMD_STOP;
      bus.speed_level <= '0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.overrun <= 1'b0;
      if (s1_valid) begin
        bus.cmd_valid   <= 1'b1;
        bus.move_cmd    <= s1_cmd;
        bus.speed_level <= s1_spd;
        bus.overrun     <= bus.cmd_valid && !bus.cmd_ready;
      end else if (bus.cmd_valid && bus.cmd_ready) begin
        bus.cmd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_auto_steer_ctrl.sv
// Directed bench for auto_steer_ctrl: default-gain instance plus a K_D=64 instance.
module tb_auto_steer_ctrl;
  logic clk;
  logic reset_n;
  logic [1:0] state_a;
  logic [1:0] state_k;
  int errors = 0;
  int checks = 0;

  auto_steer_ctrl_if #(.ERR_W(32), .SPEED_W(4)) a_if ();
  auto_steer_ctrl_if #(.ERR_W(32), .SPEED_W(4)) k_if ();

  auto_steer_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (a_if.master),
    .state   (state_a)
  );

  auto_steer_ctrl #(.K_D(16'sd64)) dut_kd (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (k_if.master),
    .state   (state_k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe one sample, then wait until its command is visible (two edges later).
  task automatic sample_a(input int e, input logic lost);
    @(negedge clk);
    a_if.error = e; a_if.error_valid = 1'b1; a_if.line_lost = lost;
    @(negedge clk);
    a_if.error_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic sample_k(input int e, input logic lost);
    @(negedge clk);
    k_if.error = e; k_if.error_valid = 1'b1; k_if.line_lost = lost;
    @(negedge clk);
    k_if.error_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] mc, input logic [3:0] sp,
                         input logic [1:0] st);
    check({tag, "_valid"}, 32'(a_if.cmd_valid), 32'd1);
    check({tag, "_cmd"},   32'(a_if.move_cmd), 32'(mc));
    check({tag, "_speed"}, 32'(a_if.speed_level), 32'(sp));
    check({tag, "_state"}, 32'(state_a), 32'(st));
  endtask

  task automatic check_k(input string tag, input logic [3:0] mc, input logic [3:0] sp,
                         input logic [1:0] st);
    check({tag, "_valid"}, 32'(k_if.cmd_valid), 32'd1);
    check({tag, "_cmd"},   32'(k_if.move_cmd), 32'(mc));
    check({tag, "_speed"}, 32'(k_if.speed_level), 32'(sp));
    check({tag, "_state"}, 32'(state_k), 32'(st));
  endtask

  initial begin
    reset_n = 1'b0;
    a_if.error = 0; a_if.error_valid = 1'b0; a_if.line_lost = 1'b0; a_if.cmd_ready = 1'b1;
    k_if.error = 0; k_if.error_valid = 1'b0; k_if.line_lost = 1'b0; k_if.cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    check("rst_valid",   32'(a_if.cmd_valid), 32'd0);
    check("rst_cmd",     32'(a_if.move_cmd), 32'h8);
    check("rst_speed",   32'(a_if.speed_level), 32'd0);
    check("rst_state",   32'(state_a), 32'd0);
    check("rst_overrun", 32'(a_if.overrun), 32'd0);

    // Tracking decode: 710>>>6=11, -710>>>6=-12, 7100>>>6=110 saturates, 0 straight
    sample_a(10, 1'b0);   check_a("e10",   4'b0001, 4'd11, 2'd0);
    sample_a(-10, 1'b0);  check_a("em10",  4'b0010, 4'd12, 2'd0);
    sample_a(100, 1'b0);  check_a("e100",  4'b0001, 4'd15, 2'd0);
    sample_a(0, 1'b0);    check_a("e0",    4'b0000, 4'd1,  2'd0);
    @(posedge clk); #1;
    check("handshake_drop", 32'(a_if.cmd_valid), 32'd0);

    // Lost-line search after a left turn, then give up, then re-acquire
    sample_a(10, 1'b0);   check_a("pre_lost", 4'b0001, 4'd11, 2'd0);
    for (int i = 1; i <= 30; i++) begin
      sample_a(0, 1'b1);
      check_a($sformatf("search%0d", i), 4'b0100, 4'd5, 2'd1);
    end
    sample_a(0, 1'b1);    check_a("give_up", 4'b1000, 4'd0, 2'd2);
    sample_a(0, 1'b1);    check_a("lost_hold", 4'b1000, 4'd0, 2'd2);
    sample_a(0, 1'b0);    check_a("reacq", 4'b0000, 4'd1, 2'd0);

    // Right-turn search emits D; re-acquire from SEARCH
    sample_a(-10, 1'b0);  check_a("pre_d", 4'b0010, 4'd12, 2'd0);
    sample_a(0, 1'b1);    check_a("search_d", 4'b0101, 4'd5, 2'd1);
    sample_a(10, 1'b0);   check_a("reacq_s", 4'b0001, 4'd11, 2'd0);

    // Back-to-back samples with consumer ready: load and handshake in the same cycle
    @(negedge clk);
    a_if.error = 10; a_if.error_valid = 1'b1; a_if.line_lost = 1'b0;
    @(negedge clk);
    a_if.error = -10;
    @(negedge clk);
    a_if.error_valid = 1'b0;
    check_a("b2b_first", 4'b0001, 4'd11, 2'd0);
    @(posedge clk); #1;
    check_a("b2b_second", 4'b0010, 4'd12, 2'd0);
    check("b2b_no_overrun", 32'(a_if.overrun), 32'd0);
    @(posedge clk); #1;
    check("b2b_drop", 32'(a_if.cmd_valid), 32'd0);

    // Back-pressure: second result overwrites the held one
    @(negedge clk);
    a_if.cmd_ready = 1'b0;
    a_if.error = 10; a_if.error_valid = 1'b1; a_if.line_lost = 1'b0;
    @(negedge clk);
    a_if.error = -10;
    @(negedge clk);
    a_if.error_valid = 1'b0;
    check_a("bp_first", 4'b0001, 4'd11, 2'd0);
    check("bp_first_ovr", 32'(a_if.overrun), 32'd0);
    @(posedge clk); #1;
    check_a("bp_over", 4'b0010, 4'd12, 2'd0);
    check("bp_ovr_pulse", 32'(a_if.overrun), 32'd1);
    @(posedge clk); #1;
    check_a("bp_hold", 4'b0010, 4'd12, 2'd0);
    check("bp_ovr_clear", 32'(a_if.overrun), 32'd0);
    @(negedge clk);
    a_if.cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_accept_drop", 32'(a_if.cmd_valid), 32'd0);

    // Derivative instance: d=0 first, then 568+512=1080>>>6=16 saturates
    sample_k(0, 1'b0);    check_k("kd_first", 4'b0000, 4'd1, 2'd0);
    sample_k(8, 1'b0);    check_k("kd_deriv", 4'b0001, 4'd15, 2'd0);
    sample_k(0, 1'b1);    check_k("kd_lost", 4'b0100, 4'd5, 2'd1);
    sample_k(8, 1'b0);    check_k("kd_reacq", 4'b0001, 4'd8, 2'd0);

    // Asynchronous reset while searching
    sample_a(10, 1'b0);   check_a("pre_rst", 4'b0001, 4'd11, 2'd0);
    sample_a(0, 1'b1);    check_a("rst_search", 4'b0100, 4'd5, 2'd1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(a_if.cmd_valid), 32'd0);
    check("arst_cmd",   32'(a_if.move_cmd), 32'h8);
    check("arst_speed", 32'(a_if.speed_level), 32'd0);
    check("arst_state", 32'(state_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sample_a(0, 1'b1);    check_a("post_rst_lost", 4'b1000, 4'd0, 2'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
